io_uart: RTL and testbench
==========================

# io_uart

Serial-line endpoint for the core's byte I/O ports: the far end of the `io_o_*` / `io_i_*` valid/ready streams. It accepts bytes the core emits on `io_o_*` and shifts them out as 8N1 UART frames. It deserialises 8N1 frames arriving on the RX pin and presents each byte to the core on `io_i_*`. Sits between `core` and the board pins at the top level.

## Interface
- `CLK_PER_BIT`, 868, clock cycles per serial bit (100 MHz / 115200); must be >= 4.
- `clk`  in  1  system clock, all state on rising edge.
- `nrst`  in  1  reset, asynchronous, active-low.
- `io_o_data`  in  8  byte from core to transmit.
- `io_o_valid`  in  1  core offers `io_o_data`.
- `io_o_ready`  out  1  block accepts a byte this cycle.
- `io_i_data`  out  8  received byte to core.
- `io_i_valid`  out  1  `io_i_data` holds an unconsumed byte.
- `io_i_ready`  in  1  core consumes the byte this cycle.
- `uart_txd`  out  1  serial output, idle high.
- `uart_rxd`  in  1  serial input, asynchronous to `clk`.
- `rx_overrun`  out  1  sticky: a received byte was dropped because the holding register was full.
- `rx_frame_err`  out  1  one-cycle pulse: stop bit sampled low.

## Operation
- Reset values: `io_o_ready`=1, `uart_txd`=1, `io_i_valid`=0, `io_i_data`=0, `rx_overrun`=0, `rx_frame_err`=0. Both FSMs are in IDLE and all counters are 0.
- Bit counter width is clog2(CLK_PER_BIT). The bit index is 3 bits and counts 0..7; it must not wrap into a ninth data bit.
- TX FSM states are IDLE, START, DATA, STOP.
  - `io_o_ready` = (state == IDLE).
  - A transfer happens on a cycle with `io_o_valid && io_o_ready`. The byte is latched into a shift register, and the FSM moves to START.
  - START drives `uart_txd`=0 for CLK_PER_BIT cycles.
  - DATA drives 8 bits LSB first, each for CLK_PER_BIT cycles.
  - STOP drives 1 for CLK_PER_BIT cycles, then returns to IDLE.
  - `io_o_data` may change after acceptance with no effect on the frame.
- The RX input passes through a 2-flop synchroniser. All RX decisions use the synchronised signal.
- RX FSM states are IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: a sampled 0 moves the FSM to START.
  - START: after CLK_PER_BIT/2 cycles, resample. 0 moves to DATA. 1 is a glitch and returns to IDLE with no output.
  - DATA: sample every CLK_PER_BIT cycles, 8 samples, shifted in LSB first.
  - STOP: sample after a further CLK_PER_BIT cycles.
    - Sample 1: the byte is complete, FSM returns to IDLE.
    - Sample 0: pulse `rx_frame_err`, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until the line samples 1, then go to IDLE. This prevents a break condition from being read as repeated frames.
- Holding register handshake on `io_i_*`:
  - A completed byte loads `io_i_data` and sets `io_i_valid`.
  - `io_i_valid` stays high, and `io_i_data` stays stable, until a cycle with `io_i_valid && io_i_ready`. It clears on that cycle unless a new byte completes on the same cycle.
  - Byte completes while `io_i_valid`=1 and `io_i_ready`=0: the new byte is dropped, `io_i_data` is unchanged, and `rx_overrun` is set. `rx_overrun` clears only on reset.
  - Byte completes on the same cycle the old byte is consumed: the new byte loads and `io_i_valid` stays 1. This is not an overrun.
- TX and RX are fully independent; simultaneous activity is legal.
- `nrst` asserted mid-frame aborts both directions immediately. `uart_txd` goes to 1 asynchronously and any held RX byte is lost.

## Timing
- `io_o_ready` falls the cycle after acceptance.
- `uart_txd` falls on the first edge after acceptance. The frame lasts exactly 10*CLK_PER_BIT cycles.
- `io_o_ready` returns to 1 on the cycle after the last STOP cycle. Back-to-back bytes therefore have a minimum frame-to-frame period of 10*CLK_PER_BIT + 1 cycles.
- RX latency runs from the first `clk` edge that sees `uart_rxd`=0 to `io_i_valid`=1. It is 2 (synchroniser) + CLK_PER_BIT/2 + 9*CLK_PER_BIT + 1 cycles, with a tolerance of ±1 cycle.
- `rx_frame_err` is high for exactly one cycle, at the STOP sample point.
- No combinational path exists from any input to any output.

## Test plan
All scenarios use CLK_PER_BIT=8.
- Reset, then idle for 100 cycles: `uart_txd`=1, `io_o_ready`=1, `io_i_valid`=0, both error flags 0.
- TX 0xA5 with `io_o_valid` held one cycle: `uart_txd` reads 0,1,0,1,0,0,1,0,1,1, 8 cycles per bit. `io_o_ready` is low for 80 cycles. A second byte 0x3C offered immediately is accepted only after the frame ends.
- Drive an RX frame of 0x5A with `io_i_ready`=0: `io_i_valid` rises about 78 cycles after the start edge with `io_i_data`=0x5A. It holds through 50 cycles. Pulsing `io_i_ready` clears it next cycle.
- Two RX frames 0x11 then 0x22, never consumed: `io_i_data` stays 0x11 and `rx_overrun`=1. Repeat with `io_i_ready` pulsed exactly at the second completion: `io_i_data`=0x22, `io_i_valid` stays 1, `rx_overrun` stays 0.
- RX error cases:
  - Frame 0xFF with the stop bit forced 0, then line held 0 for 200 cycles: one `rx_frame_err` pulse, no `io_i_valid`, no further frames.
  - 2-cycle low glitch on an idle line: no output.
- `nrst` pulsed low mid-TX at bit 4 and mid-RX: `uart_txd`=1 immediately, all outputs return to reset values. A subsequent 0x81 TX/RX loopback (`uart_txd` tied to `uart_rxd`) delivers 0x81.

Source files
------------

// File: rtl/io_uart.sv
// 8N1 UART endpoint bridging the core's io_o_*/io_i_* byte streams to the board pins.
// The TX and RX halves run independently. Every output comes straight from a flop.
module io_uart #(
  parameter int unsigned CLK_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] io_o_data,
  input  logic       io_o_valid,
  output logic       io_o_ready,
  output logic [7:0] io_i_data,
  output logic       io_i_valid,
  input  logic       io_i_ready,
  output logic       uart_txd,
  input  logic       uart_rxd,
  output logic       rx_overrun,
  output logic       rx_frame_err
);

  localparam int unsigned CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_e;

  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          tx_ready_q, tx_ready_d;
  logic          txd_q, txd_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_ready_d = tx_ready_q;
    txd_d      = txd_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (io_o_valid) begin
          tx_state_d = TX_START;
          tx_sh_d    = io_o_data;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          txd_d      = 1'b0;
          tx_ready_d = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_DATA;
          txd_d      = tx_sh_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            txd_d      = 1'b1;
          end else begin
            // txd is registered, so drive the bit that becomes LSB after this shift
            tx_bit_d = tx_bit_q + 3'd1;
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            txd_d    = tx_sh_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
          tx_ready_d = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_ready_q <= 1'b1;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_ready_q <= tx_ready_d;
      txd_q      <= txd_d;
    end
  end

  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_ovr_q, rx_ovr_d;
  logic          rx_ferr_q, rx_ferr_d;
  logic          rx_done;

  always_comb begin
    rx_meta_d  = uart_rxd;
    rx_sync_d  = rx_meta_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_ovr_d   = rx_ovr_q;
    rx_ferr_d  = 1'b0;
    rx_done    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          if (rx_sync_q) begin
            rx_state_d = RX_IDLE;
            rx_done    = 1'b1;
          end else begin
            rx_ferr_d  = 1'b1;
            rx_state_d = RX_WAIT_HIGH;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_sync_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase

    // A byte completing in the same cycle as a consume replaces the old one
    if (rx_done) begin
      if (!rx_valid_q || io_i_ready) begin
        rx_data_d  = rx_sh_q;
        rx_valid_d = 1'b1;
      end else begin
        rx_ovr_d = 1'b1;
      end
    end else if (rx_valid_q && io_i_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_meta_q  <= rx_meta_d;
      rx_sync_q  <= rx_sync_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  assign io_o_ready   = tx_ready_q;
  assign uart_txd     = txd_q;
  assign io_i_data    = rx_data_q;
  assign io_i_valid   = rx_valid_q;
  assign rx_overrun   = rx_ovr_q;
  assign rx_frame_err = rx_ferr_q;

endmodule

// File: tb/tb_io_uart.sv
// Self-checking bench for io_uart at CLK_PER_BIT=8: TX frame shape, RX delivery,
// holding-register handshake, error cases, async reset and loopback.
module tb_io_uart;

  localparam int unsigned CPB   = 8;
  localparam int          FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  logic [7:0] io_o_data = '0;
  logic       io_o_valid = 1'b0;
  logic       io_o_ready;
  logic [7:0] io_i_data;
  logic       io_i_valid;
  logic       io_i_ready = 1'b0;
  logic       uart_txd;
  logic       uart_rxd;
  logic       rx_overrun;
  logic       rx_frame_err;
  logic       rxd_drv = 1'b1;
  logic       loopback = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  // Reference holding register: what the core should see after each completed frame
  logic       m_valid = 1'b0;
  logic [7:0] m_data  = '0;
  logic       m_ovr   = 1'b0;

  assign uart_rxd = loopback ? uart_txd : rxd_drv;

  always #5 clk = ~clk;

  io_uart #(.CLK_PER_BIT(CPB)) dut (
    .clk(clk), .nrst(nrst),
    .io_o_data(io_o_data), .io_o_valid(io_o_valid), .io_o_ready(io_o_ready),
    .io_i_data(io_i_data), .io_i_valid(io_i_valid), .io_i_ready(io_i_ready),
    .uart_txd(uart_txd), .uart_rxd(uart_rxd),
    .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err)
  );

  function automatic void model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_ovr   = 1'b0;
  endfunction

  function automatic void model_arrive(input logic [7:0] b, input logic rdy);
    if (!m_valid || rdy) begin
      m_data  = b;
      m_valid = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
  endfunction

  // Line level i cycles into a frame: start bit, 8 data bits LSB first, stop bit
  function automatic logic tx_level(input logic [7:0] b, input int i);
    int slot;
    slot = i / CPB;
    if (slot == 0) return 1'b0;
    if (slot >= 9) return 1'b1;
    return b[slot-1];
  endfunction

  task automatic drive_rx(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rxd_drv = bits[i];
      repeat (CPB - 1) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    io_o_valid = 1'b0;
    io_i_ready = 1'b0;
    rxd_drv = 1'b1;
    loopback = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    model_reset();
  endtask

  task automatic test_reset();
    #2 nrst = 1'b0;
    #1;
    n_cmp++;
    if (uart_txd !== 1'b1 || io_o_ready !== 1'b1 || io_i_valid !== 1'b0 || io_i_data !== 8'h00 ||
        rx_overrun !== 1'b0 || rx_frame_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values: txd=%b ready=%b ivalid=%b idata=%h ovr=%b ferr=%b, required 1 1 0 00 0 0",
               uart_txd, io_o_ready, io_i_valid, io_i_data, rx_overrun, rx_frame_err);
    end
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      n_cmp++;
      if (uart_txd !== 1'b1 || io_o_ready !== 1'b1 || io_i_valid !== 1'b0 ||
          rx_overrun !== 1'b0 || rx_frame_err !== 1'b0) begin
        n_err++;
        $display("FAIL idle_cycle%0d: txd=%b ready=%b ivalid=%b ovr=%b ferr=%b, required 1 1 0 0 0",
                 c, uart_txd, io_o_ready, io_i_valid, rx_overrun, rx_frame_err);
      end
    end
  endtask

  task automatic test_tx();
    logic [7:0] q[$];
    logic exp;
    q.push_back(8'hA5);
    q.push_back(8'h3C);
    repeat (3) q.push_back(8'($urandom));
    @(negedge clk);
    io_o_valid = 1'b1;
    io_o_data  = q[0];
    for (int k = 0; k < q.size(); k++) begin
      if (k > 0) @(negedge clk);
      n_cmp++;
      if (io_o_ready !== 1'b1 || uart_txd !== 1'b1) begin
        n_err++;
        $display("FAIL tx_ready_before_byte%0d: ready=%b txd=%b, required 1 1", k, io_o_ready, uart_txd);
      end
      @(negedge clk);
      // Next byte is offered right away (or data scrambled) to prove the frame is latched
      if (k + 1 < q.size()) io_o_data = q[k+1];
      else begin
        io_o_valid = 1'b0;
        io_o_data  = 8'($urandom);
      end
      for (int i = 0; i < FRAME; i++) begin
        if (i > 0) @(negedge clk);
        exp = tx_level(q[k], i);
        n_cmp++;
        if (uart_txd !== exp || io_o_ready !== 1'b0) begin
          n_err++;
          $display("FAIL tx_byte%h_cycle%0d: txd=%b ready=%b, required txd=%b ready=0",
                   q[k], i, uart_txd, io_o_ready, exp);
        end
      end
    end
    @(negedge clk);
    n_cmp++;
    if (io_o_ready !== 1'b1 || uart_txd !== 1'b1) begin
      n_err++;
      $display("FAIL tx_return_idle: ready=%b txd=%b, required 1 1", io_o_ready, uart_txd);
    end
  endtask

  task automatic test_rx();
    logic [7:0] b;
    int lat;
    for (int t = 0; t < 4; t++) begin
      b = (t == 0) ? 8'h5A : 8'($urandom);
      io_i_ready = 1'b0;
      lat = -1;
      fork
        drive_rx(b, 1'b1);
        begin
          @(negedge clk);
          for (int k = 0; k <= 120; k++) begin
            @(negedge clk);
            if (io_i_valid === 1'b1) begin
              lat = k;
              break;
            end
          end
        end
      join
      model_arrive(b, 1'b0);
      n_cmp++;
      if (lat < 78 || lat > 80) begin
        n_err++;
        $display("FAIL rx_latency_%h: got %0d cycles (-1 = never), required 78..80", b, lat);
      end
      n_cmp++;
      if (io_i_data !== m_data) begin
        n_err++;
        $display("FAIL rx_data: got %h, required %h", io_i_data, m_data);
      end
      if (t == 0) begin
        for (int c = 0; c < 50; c++) begin
          @(negedge clk);
          n_cmp++;
          if (io_i_valid !== 1'b1 || io_i_data !== m_data) begin
            n_err++;
            $display("FAIL rx_hold_cycle%0d: valid=%b data=%h, required 1 %h", c, io_i_valid, io_i_data, m_data);
          end
        end
      end
      io_i_ready = 1'b1;
      @(negedge clk);
      io_i_ready = 1'b0;
      m_valid = 1'b0;
      n_cmp++;
      if (io_i_valid !== m_valid) begin
        n_err++;
        $display("FAIL rx_consume: valid=%b, required 0", io_i_valid);
      end
    end
  endtask

  task automatic test_overrun();
    int lat1;
    int cur;
    do_reset();
    fork
      begin drive_rx(8'h11, 1'b1); drive_rx(8'h22, 1'b1); end
      repeat (171) @(negedge clk);
    join
    model_arrive(8'h11, 1'b0);
    model_arrive(8'h22, 1'b0);
    n_cmp++;
    if (io_i_valid !== m_valid || io_i_data !== m_data || rx_overrun !== m_ovr) begin
      n_err++;
      $display("FAIL overrun_drop: valid=%b data=%h ovr=%b, required %b %h %b",
               io_i_valid, io_i_data, rx_overrun, m_valid, m_data, m_ovr);
    end

    do_reset();
    lat1 = -1;
    fork
      begin drive_rx(8'h11, 1'b1); drive_rx(8'h22, 1'b1); end
      begin
        @(negedge clk);
        for (int k = 0; k <= 120; k++) begin
          @(negedge clk);
          if (io_i_valid === 1'b1) begin
            lat1 = k;
            break;
          end
        end
        if (lat1 >= 0) begin
          // Second frame starts 80 cycles after the first, so it completes at 80+lat1
          cur = lat1 + 1;
          while (cur < 80 + lat1) begin
            @(negedge clk);
            cur++;
          end
          io_i_ready = 1'b1;
          @(negedge clk);
          io_i_ready = 1'b0;
        end
      end
    join
    repeat (5) @(negedge clk);
    n_cmp++;
    if (lat1 < 0) begin
      n_err++;
      $display("FAIL swap_first_frame: valid never rose, required within 120 cycles");
    end
    model_arrive(8'h11, 1'b0);
    model_arrive(8'h22, 1'b1);
    n_cmp++;
    if (io_i_valid !== m_valid || io_i_data !== m_data || rx_overrun !== m_ovr) begin
      n_err++;
      $display("FAIL consume_and_load_same_cycle: valid=%b data=%h ovr=%b, required %b %h %b",
               io_i_valid, io_i_data, rx_overrun, m_valid, m_data, m_ovr);
    end
  endtask

  task automatic test_rx_errors();
    int ferr_cycles;
    int ferr_first;
    int valid_cycles;
    do_reset();
    ferr_cycles = 0;
    ferr_first = -1;
    valid_cycles = 0;
    fork
      begin
        drive_rx(8'hFF, 1'b0);
        repeat (200) @(negedge clk);
        rxd_drv = 1'b1;
      end
      begin
        @(negedge clk);
        for (int k = 0; k < 320; k++) begin
          @(negedge clk);
          if (rx_frame_err === 1'b1) begin
            ferr_cycles++;
            if (ferr_first < 0) ferr_first = k;
          end
          if (io_i_valid !== 1'b0) valid_cycles++;
        end
      end
    join
    n_cmp++;
    if (ferr_cycles != 1) begin
      n_err++;
      $display("FAIL frame_err_pulse_count: high for %0d cycles, required 1", ferr_cycles);
    end
    n_cmp++;
    if (ferr_first < 78 || ferr_first > 80) begin
      n_err++;
      $display("FAIL frame_err_timing: at cycle %0d, required 78..80", ferr_first);
    end
    n_cmp++;
    if (valid_cycles != 0 || rx_overrun !== 1'b0) begin
      n_err++;
      $display("FAIL break_no_output: valid cycles=%0d ovr=%b, required 0 0", valid_cycles, rx_overrun);
    end

    ferr_cycles = 0;
    valid_cycles = 0;
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (2) @(negedge clk);
    rxd_drv = 1'b1;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (rx_frame_err !== 1'b0) ferr_cycles++;
      if (io_i_valid !== 1'b0) valid_cycles++;
    end
    n_cmp++;
    if (ferr_cycles != 0 || valid_cycles != 0) begin
      n_err++;
      $display("FAIL glitch_ignored: ferr cycles=%0d valid cycles=%0d, required 0 0", ferr_cycles, valid_cycles);
    end
  endtask

  task automatic test_reset_midframe_loopback();
    logic [7:0] txb;
    int lat;
    int bad;
    do_reset();
    fork
      drive_rx(8'($urandom), 1'b1);
      repeat (95) @(negedge clk);
    join
    n_cmp++;
    if (io_i_valid !== 1'b1) begin
      n_err++;
      $display("FAIL held_byte_before_reset: valid=%b, required 1", io_i_valid);
    end
    txb = 8'($urandom);
    io_o_valid = 1'b1;
    io_o_data  = txb;
    rxd_drv    = 1'b0;
    @(negedge clk);
    io_o_valid = 1'b0;
    repeat (44) @(negedge clk);
    n_cmp++;
    if (uart_txd !== txb[4]) begin
      n_err++;
      $display("FAIL tx_bit4_before_reset: txd=%b, required %b", uart_txd, txb[4]);
    end
    #2 nrst = 1'b0;
    #1;
    n_cmp++;
    if (uart_txd !== 1'b1 || io_o_ready !== 1'b1 || io_i_valid !== 1'b0 || io_i_data !== 8'h00 ||
        rx_overrun !== 1'b0 || rx_frame_err !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset_midframe: txd=%b ready=%b ivalid=%b idata=%h ovr=%b ferr=%b, required 1 1 0 00 0 0",
               uart_txd, io_o_ready, io_i_valid, io_i_data, rx_overrun, rx_frame_err);
    end
    @(negedge clk);
    nrst = 1'b1;
    rxd_drv = 1'b1;
    model_reset();
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1 || io_o_ready !== 1'b1 || io_i_valid !== 1'b0 || rx_frame_err !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL quiet_after_reset: %0d bad cycles, required 0", bad);
    end

    loopback = 1'b1;
    io_o_valid = 1'b1;
    io_o_data  = 8'h81;
    @(negedge clk);
    io_o_valid = 1'b0;
    lat = -1;
    bad = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (rx_frame_err !== 1'b0) bad++;
      if (io_i_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    model_arrive(8'h81, 1'b0);
    n_cmp++;
    if (lat < 0 || io_i_data !== m_data || bad != 0) begin
      n_err++;
      $display("FAIL loopback: valid_at=%0d data=%h ferr_cycles=%0d, required valid within 150, data %h, 0",
               lat, io_i_data, bad, m_data);
    end
    loopback = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_tx();
    test_rx();
    test_overrun();
    test_rx_errors();
    test_reset_midframe_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
